// File: rtl/aes_pkg.sv
// Shared AES constants: FSM state encoding, round constants and the forward S-box.
// The S-box table is also used by the cipher round datapath.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  // RCON[r-1] is the round constant for round r (1..10).
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: a single 8-bit table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: emits round keys 0..NUM_ROUNDS as a ready/valid stream,
// driven by the same level-held start/finish handshake as the newkey block.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rkey_ready,
  output logic [127:0] rkey,
  output logic         rkey_valid,
  output logic [3:0]   rkey_idx,
  output logic         finish
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_e         r_state;
  logic [127:0]   r_rkey;
  logic           r_valid;
  logic [3:0]     r_idx;
  logic           r_finish;

  logic [31:0]    w_w3;
  logic [31:0]    w_rot;
  logic [31:0]    w_sub;
  logic [31:0]    w_t;
  logic [31:0]    w_n0, w_n1, w_n2, w_n3;
  logic [7:0]     w_rcon;
  logic [127:0]   w_next;
  logic           w_accept;

  // Byte packing is little-endian, so RotWord moves the lowest byte to the top.
  assign w_w3  = r_rkey[127:96];
  assign w_rot = {w_w3[7:0], w_w3[31:8]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*i +: 8]),
      .o_byte (w_sub[8*i +: 8])
    );
  end

  // The key being computed is round r_idx+1, whose constant sits at RCON[r_idx].
  assign w_rcon = (r_idx < 4'd10) ? RCON[r_idx] : 8'h00;
  assign w_t    = w_sub ^ {24'h0, w_rcon};
  assign w_n0   = r_rkey[31:0]   ^ w_t;
  assign w_n1   = r_rkey[63:32]  ^ w_n0;
  assign w_n2   = r_rkey[95:64]  ^ w_n1;
  assign w_n3   = r_rkey[127:96] ^ w_n2;
  assign w_next = {w_n3, w_n2, w_n1, w_n0};

  assign w_accept = r_valid && rkey_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rkey   <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_finish <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_valid  <= 1'b0;
          r_finish <= 1'b0;
          if (start) begin
            r_rkey  <= key;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_state <= EXPAND;
          end
        end
        EXPAND: begin
          if (!start) begin
            r_valid  <= 1'b0;
            r_finish <= 1'b0;
            r_idx    <= '0;
            r_state  <= IDLE;
          end else if (w_accept && r_idx == LAST_IDX) begin
            r_valid  <= 1'b0;
            r_finish <= 1'b1;
            r_state  <= DONE;
          end else if (w_accept) begin
            r_rkey <= w_next;
            r_idx  <= r_idx + 4'd1;
          end
        end
        DONE: begin
          r_valid <= 1'b0;
          if (!start) begin
            r_finish <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rkey       = r_rkey;
  assign rkey_valid = r_valid;
  assign rkey_idx   = r_idx;
  assign finish     = r_finish;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 A.1 expansion, backpressure, abort,
// finish protocol, asynchronous reset and a NUM_ROUNDS=1 build.
module tb_aes_key_schedule;

  localparam logic [127:0] KEY_A1 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

  // FIPS-197 A.1 round keys written as in the standard (w[4r] first, big-endian bytes).
  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         rkey_ready = 1'b0;
  logic [127:0] rkey;
  logic         rkey_valid;
  logic [3:0]   rkey_idx;
  logic         finish;

  logic         start1 = 1'b0;
  logic [127:0] key1 = '0;
  logic         rkey_ready1 = 1'b0;
  logic [127:0] rkey1;
  logic         rkey_valid1;
  logic [3:0]   rkey_idx1;
  logic         finish1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .rkey_ready (rkey_ready),
    .rkey       (rkey),
    .rkey_valid (rkey_valid),
    .rkey_idx   (rkey_idx),
    .finish     (finish)
  );

  aes_key_schedule #(.NUM_ROUNDS(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .key        (key1),
    .rkey_ready (rkey_ready1),
    .rkey       (rkey1),
    .rkey_valid (rkey_valid1),
    .rkey_idx   (rkey_idx1),
    .finish     (finish1)
  );

  // Round key k of the A.1 key in the block's little-endian byte packing.
  function automatic logic [127:0] exp_rk(input int k);
    logic [127:0] src;
    logic [127:0] dst;
    src = FIPS_RK[k];
    for (int i = 0; i < 16; i++) dst[8*i +: 8] = src[8*(15-i) +: 8];
    return dst;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_key(input string name, input int idx, input logic [127:0] rk);
    total++;
    if (rkey_valid !== 1'b1 || rkey_idx !== 4'(idx) || rkey !== rk || finish !== 1'b0) begin
      bad++;
      $display("FAIL %s: valid=%b idx=%0d rkey=%h finish=%b, want valid=1 idx=%0d rkey=%h finish=0",
               name, rkey_valid, rkey_idx, rkey, finish, idx, rk);
    end
  endtask

  task automatic expect_quiet(input string name, input logic fin);
    total++;
    if (rkey_valid !== 1'b0 || finish !== fin) begin
      bad++;
      $display("FAIL %s: valid=%b finish=%b, want valid=0 finish=%b", name, rkey_valid, finish, fin);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (rkey !== '0 || rkey_valid !== 1'b0 || rkey_idx !== 4'd0 || finish !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: rkey=%h valid=%b idx=%0d finish=%b, want all zero",
               rkey, rkey_valid, rkey_idx, finish);
    end
    total++;
    if (rkey1 !== '0 || rkey_valid1 !== 1'b0 || rkey_idx1 !== 4'd0 || finish1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs_nr1: rkey=%h valid=%b idx=%0d finish=%b, want all zero",
               rkey1, rkey_valid1, rkey_idx1, finish1);
    end
    // start high during reset must not begin a run
    start = 1'b1;
    tick();
    expect_quiet("start_during_reset", 1'b0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    expect_quiet("idle_after_release", 1'b0);
  endtask

  task automatic test_fips_a1();
    key = KEY_A1;
    rkey_ready = 1'b1;
    start = 1'b1;
    tick();
    // key is ignored once latched
    key = ~KEY_A1;
    for (int k = 0; k <= 10; k++) begin
      expect_key($sformatf("a1_idx%0d", k), k, exp_rk(k));
      tick();
    end
    expect_quiet("a1_finish_after_11_edges", 1'b1);
  endtask

  task automatic test_finish_protocol();
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_quiet($sformatf("done_hold_%0d", c), 1'b1);
    end
    start = 1'b0;
    tick();
    expect_quiet("done_drop_start", 1'b0);
    key = KEY_A1;
    start = 1'b1;
    tick();
    expect_key("fresh_run_idx0", 0, exp_rk(0));
    start = 1'b0;
    tick();
    expect_quiet("fresh_run_abort", 1'b0);
  endtask

  task automatic test_backpressure();
    int  exp_idx;
    bit  done;
    bit  acc;
    key = KEY_A1;
    rkey_ready = 1'b0;
    start = 1'b1;
    tick();
    exp_idx = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      expect_key($sformatf("bp_cycle%0d", c), exp_idx, exp_rk(exp_idx));
      acc = (c % 3 == 0);
      rkey_ready = acc;
      tick();
      if (acc) begin
        if (exp_idx == 10) done = 1'b1;
        else exp_idx++;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL bp_timeout: last accepted idx=%0d, want 10", exp_idx);
    end
    expect_quiet("bp_finish", 1'b1);
    rkey_ready = 1'b1;
    start = 1'b0;
    tick();
    expect_quiet("bp_back_to_idle", 1'b0);
  endtask

  task automatic test_abort();
    key = KEY_A1;
    rkey_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    expect_key("abort_at_idx4", 4, exp_rk(4));
    start = 1'b0;
    tick();
    expect_quiet("abort_idle", 1'b0);
    total++;
    if (rkey_idx !== 4'd0) begin
      bad++;
      $display("FAIL abort_idx: idx=%0d, want 0", rkey_idx);
    end
    key = '0;
    start = 1'b1;
    tick();
    expect_key("restart_zero_idx0", 0, 128'h0);
    tick();
    expect_key("restart_zero_idx1", 1, 128'h63636362636363626363636263636362);
    tick();
    expect_key("restart_zero_idx2", 2, 128'haafbfbf9c998989baafbfbf9c998989b);
  endtask

  task automatic test_async_reset();
    // still in EXPAND from the zero-key run
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (rkey !== '0 || rkey_valid !== 1'b0 || rkey_idx !== 4'd0 || finish !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: rkey=%h valid=%b idx=%0d finish=%b, want all zero",
               rkey, rkey_valid, rkey_idx, finish);
    end
    start = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    expect_quiet("post_reset_idle", 1'b0);
    key = KEY_A1;
    start = 1'b1;
    tick();
    expect_key("post_reset_run", 0, exp_rk(0));
    start = 1'b0;
    tick();
  endtask

  task automatic test_num_rounds_1();
    key1 = KEY_A1;
    rkey_ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    total++;
    if (rkey_valid1 !== 1'b1 || rkey_idx1 !== 4'd0 || rkey1 !== KEY_A1) begin
      bad++;
      $display("FAIL nr1_idx0: valid=%b idx=%0d rkey=%h, want 1/0/%h", rkey_valid1, rkey_idx1, rkey1, KEY_A1);
    end
    tick();
    total++;
    if (rkey_valid1 !== 1'b1 || rkey_idx1 !== 4'd1 || rkey1 !== 128'h05766c2a3939a323b12c548817fefaa0) begin
      bad++;
      $display("FAIL nr1_idx1: valid=%b idx=%0d rkey=%h, want 1/1/05766c2a3939a323b12c548817fefaa0",
               rkey_valid1, rkey_idx1, rkey1);
    end
    tick();
    total++;
    if (rkey_valid1 !== 1'b0 || finish1 !== 1'b1) begin
      bad++;
      $display("FAIL nr1_finish: valid=%b finish=%b, want 0/1", rkey_valid1, finish1);
    end
    start1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fips_a1();
    test_finish_protocol();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_num_rounds_1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Downstream of `newkey`. Consumes the 128-bit key that `newkey` produces.
- Expands it into the AES-128 round keys (round 0 .. NUM_ROUNDS), one per handshake.
- Output is a ready/valid stream for the cipher round datapath.
- Uses the same level-held start/finish protocol as `newkey`, so a controller can chain the two.

Parameters:
- NUM_ROUNDS, 10, index of the last round key emitted. Legal range 1..10, because the rcon table has 10 entries. Full AES-128 = 10.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  level-held request. Key is latched when sampled high in IDLE. Dropping it returns the block to IDLE.
- key  in  128  cipher key. Byte i is at [8i+7:8i]; word j is at [32j+31:32j]. Normally driven from `newkey.newkey`.
- rkey_ready  in  1  downstream accepts rkey this cycle.
- rkey  out  128  current round key, same byte packing as key.
- rkey_valid  out  1  rkey holds a valid round key.
- rkey_idx  out  4  round number of rkey (0..NUM_ROUNDS).
- finish  out  1  all round keys accepted. Held until start is sampled low.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rkey=0, rkey_valid=0, rkey_idx=0, finish=0.
- All registers update on the rising edge of clk only.
- IDLE:
  - Outputs valid=0, finish=0.
  - start=1 at an edge: rkey<=key, rkey_idx<=0, rkey_valid<=1, go to EXPAND.
- EXPAND:
  - start=0 at an edge (abort, checked first): rkey_valid<=0, finish<=0, rkey_idx<=0, go to IDLE. rkey may keep its value.
  - rkey_valid && rkey_ready with rkey_idx==NUM_ROUNDS: rkey_valid<=0, finish<=1, go to DONE.
  - rkey_valid && rkey_ready with rkey_idx<NUM_ROUNDS: rkey<=next(rkey, rkey_idx+1), rkey_idx<=rkey_idx+1, rkey_valid stays 1.
  - rkey_ready=0: rkey and rkey_idx hold.
- DONE:
  - finish=1, rkey_valid=0.
  - start=0 at an edge: finish<=0, go to IDLE.
  - start held high: stays in DONE. A new run needs start low for at least one edge, then high again.
- next(k, r) (w0..w3 are the words of k):
  - t = SubWord(RotWord(w3)) ^ {24'h0, rcon[r]}.
  - RotWord(w) = {w[7:0], w[31:8]}, i.e. lowest byte moves to the top (little-endian byte packing).
  - SubWord = AES S-box applied to each of the 4 bytes.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - next = {n3, n2, n1, n0}.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Critical path: 4 S-boxes plus a 4-deep XOR chain, computed combinationally from the rkey register.
- Latency with rkey_ready tied to 1 (start sampled at edge N):
  - round key k is visible after edge N+k;
  - finish rises after edge N+NUM_ROUNDS+1.
- key is ignored after latching; changes to key mid-run have no effect.
- rst deasserted mid-run: the block is already in IDLE with all outputs 0.
- start high while rst is asserted has no effect. start must be sampled high after reset release.

Decomposition:
- aes_pkg:
  - state enum {IDLE, EXPAND, DONE};
  - RCON table (10 x 8 bits);
  - SBOX constant array (256 x 8), shared with the round datapath.
- One combinational sub-module aes_sbox (8-bit in, 8-bit out lookup from aes_pkg::SBOX), instantiated 4 times.
- Everything else lives in aes_key_schedule.

Test Plan:
- FIPS-197 A.1 key: key=128'h3c4fcf098815f7aba6d2ae2816157e2b, rkey_ready=1, start held high.
  - idx0 = key.
  - idx1 = 128'h05766c2a3939a323b12c548817fefaa0.
  - idx10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0.
  - finish rises exactly 11 edges after start is sampled.
- Backpressure: same key, rkey_ready toggling 1,0,0,1,...
  - rkey and rkey_idx stay stable whenever ready=0.
  - The sequence of accepted keys is identical to the previous scenario.
  - finish is delayed accordingly.
- Abort: start dropped while rkey_idx=4.
  - Next edge: IDLE, rkey_valid=0, finish=0.
  - Restarting with a new key begins again at idx0 = new key.
- Finish protocol: start held high after finish.
  - finish stays 1 and no new keys are emitted.
  - Drop start: finish goes 0 at the next edge.
  - Raise start again: a fresh run starts.
- Async reset: rst=0 asserted mid-EXPAND between clock edges.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release: IDLE.
- NUM_ROUNDS=1 build: A.1 key.
  - idx0 = key, then idx1 = 128'h05766c2a3939a323b12c548817fefaa0.
  - finish follows on the next edge.
